// File: rtl/lcd_char_ctrl.sv
// HD44780 character-LCD write controller: write FIFO, power-up/init ROM sequencer and E-strobe timing.
// Define LCD_NIBBLE_MODE_EN to build the 4-bit bus variant (high nibble first on lcd_db[7:4]).
module lcd_char_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int PWR_CYC    = 750000,
    parameter int CMD_CYC    = 2500,
    parameter int CLR_CYC    = 100000,
    parameter int E_CYC      = 25,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          wr_rs,
    input  logic [7:0]                    wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          init_done,
    output logic                          busy,
    output logic                          lcd_rs,
    output logic                          lcd_rw,
    output logic                          lcd_e,
    output logic [7:0]                    lcd_db
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_A   = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int MAX_B   = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
`ifdef LCD_NIBBLE_MODE_EN
    localparam int ROM_LEN = 9;
`else
    localparam int ROM_LEN = 8;
`endif

    // CLK_HZ only documents the timing assumptions behind the cycle counts.
    generate
        if (CLK_HZ <= 0) begin : g_clk_hz_unset
        end
    endgenerate

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, E_HIGH, HOLD, EXEC} state_t;

    function automatic logic [7:0] rom_byte(input logic [3:0] idx);
`ifdef LCD_NIBBLE_MODE_EN
        case (idx)
            4'd0, 4'd1, 4'd2: rom_byte = 8'h30;
            4'd3:             rom_byte = 8'h20;
            4'd4:             rom_byte = 8'h28;
            4'd5:             rom_byte = 8'h08;
            4'd6:             rom_byte = 8'h01;
            4'd7:             rom_byte = 8'h06;
            default:          rom_byte = 8'h0C;
        endcase
`else
        case (idx)
            4'd0, 4'd1, 4'd2: rom_byte = 8'h30;
            4'd3:             rom_byte = 8'h38;
            4'd4:             rom_byte = 8'h08;
            4'd5:             rom_byte = 8'h01;
            4'd6:             rom_byte = 8'h06;
            default:          rom_byte = 8'h0C;
        endcase
`endif
    endfunction

    function automatic logic is_clr(input logic [7:0] b);
        is_clr = (b == 8'h01) || (b == 8'h02);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         rom_idx_q, rom_idx_d;
    logic               init_done_q, init_done_d;
    logic               exec_long_q, exec_long_d;
    logic               lcd_e_q, lcd_e_d;
    logic               lcd_rs_q, lcd_rs_d;
    logic [7:0]         lcd_db_q, lcd_db_d;
`ifdef LCD_NIBBLE_MODE_EN
    logic [7:0]         byte_q, byte_d;
    logic               nib_q, nib_d;
`endif

    logic [8:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               push, pop, load, load_rs;
    logic [7:0]         load_byte;
    logic [8:0]         rd_entry;

    assign wr_ready   = (level_q != LVL_W'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    assign rd_entry   = mem[rd_ptr_q];
    assign fifo_level = level_q;
    assign init_done  = init_done_q;
    assign busy       = (state_q != IDLE) || (level_q != '0);
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = lcd_e_q;
    assign lcd_db     = lcd_db_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (!push && pop) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {wr_rs, wr_data};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rom_idx_d   = rom_idx_q;
        init_done_d = init_done_q;
        exec_long_d = exec_long_q;
        lcd_e_d     = lcd_e_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_db_d    = lcd_db_q;
        pop         = 1'b0;
        load        = 1'b0;
        load_rs     = 1'b0;
        load_byte   = 8'h00;
`ifdef LCD_NIBBLE_MODE_EN
        byte_d      = byte_q;
        nib_d       = nib_q;
`endif
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == CNT_W'(PWR_CYC - 1)) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INIT: begin
                load        = 1'b1;
                load_byte   = rom_byte(rom_idx_q);
                // The very first init byte needs the long wait regardless of its value.
                exec_long_d = (rom_idx_q == 4'd0) || is_clr(load_byte);
            end
            IDLE: begin
                if (init_done_q && (level_q != '0)) begin
                    pop         = 1'b1;
                    load        = 1'b1;
                    load_rs     = rd_entry[8];
                    load_byte   = rd_entry[7:0];
                    exec_long_d = !rd_entry[8] && is_clr(rd_entry[7:0]);
                end
            end
            SETUP: begin
                state_d = E_HIGH;
                lcd_e_d = 1'b1;
                cnt_d   = '0;
            end
            E_HIGH: begin
                if (cnt_q == CNT_W'(E_CYC - 1)) begin
                    state_d = HOLD;
                    lcd_e_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(E_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = EXEC;
`ifdef LCD_NIBBLE_MODE_EN
                    if (nib_q) begin
                        nib_d    = 1'b0;
                        state_d  = SETUP;
                        lcd_db_d = {byte_q[3:0], 4'h0};
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                if (cnt_q == (exec_long_q ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1))) begin
                    cnt_d = '0;
                    if (init_done_q) begin
                        state_d = IDLE;
                    end else if (rom_idx_q == 4'(ROM_LEN - 1)) begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        rom_idx_d = rom_idx_q + 4'd1;
                        state_d   = INIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = PWR_WAIT;
        endcase

        if (load) begin
            state_d  = SETUP;
            cnt_d    = '0;
            lcd_rs_d = load_rs;
`ifdef LCD_NIBBLE_MODE_EN
            lcd_db_d = {load_byte[7:4], 4'h0};
            byte_d   = load_byte;
            // The first four init entries are lone high nibbles with no second strobe.
            nib_d    = !((state_q == INIT) && (rom_idx_q < 4'd4));
`else
            lcd_db_d = load_byte;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= '0;
            rom_idx_q   <= '0;
            init_done_q <= 1'b0;
            exec_long_q <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_db_q    <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
`ifdef LCD_NIBBLE_MODE_EN
            byte_q      <= 8'h00;
            nib_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_idx_q   <= rom_idx_d;
            init_done_q <= init_done_d;
            exec_long_q <= exec_long_d;
            lcd_e_q     <= lcd_e_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_db_q    <= lcd_db_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
`ifdef LCD_NIBBLE_MODE_EN
            byte_q      <= byte_d;
            nib_q       <= nib_d;
`endif
        end
    end

endmodule
